// File: rtl/finger_game_core.sv
// Two-row finger-addition game: cursor navigation from edge-detected keys, slot
// selection, modular add into the current player's row, then win/draw evaluation.
module finger_game_core #(
  parameter int MAX_SLOTS  = 5,
  parameter int DIGIT_MOD  = 10,
  parameter int ZERO_LIMIT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [2:0]                 num_slots,
  input  logic                       key_up,
  input  logic                       key_left,
  input  logic                       key_right,
  input  logic                       key_down,
  input  logic                       key_space,
  output logic [2*MAX_SLOTS*4-1:0]   slot_vals,
  output logic                       cur_row,
  output logic [2:0]                 cur_col,
  output logic                       sel_row,
  output logic [2:0]                 sel_col,
  output logic                       selecting,
  output logic                       cur_player,
  output logic [1:0]                 game_end,
  output logic                       move_done,
  output logic [2:0]                 state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PICK_SRC = 3'd1,
    PICK_DST = 3'd2,
    APPLY    = 3'd3,
    CHECK    = 3'd4,
    END      = 3'd5
  } state_t;

  localparam logic [2:0] MAX_N = 3'(MAX_SLOTS);
  localparam logic [2:0] ZL    = 3'(ZERO_LIMIT);
  localparam logic [4:0] MOD5  = 5'(DIGIT_MOD);

  state_t     state;
  logic [3:0] vals [0:1][0:MAX_SLOTS-1];
  logic [2:0] n_act;
  logic [2:0] zero_cnt;

  // Key history: bit order {up, left, right, down, space}.
  logic [4:0] key_q;
  logic [4:0] key_prev;
  logic       primed;
  logic [4:0] ev;
  logic       act_up, act_left, act_right, act_down, act_space;

  logic [2:0] n_new;
  logic [2:0] n_m1;
  logic       nxt_row;
  logic [2:0] nxt_col;

  logic [2:0] tgt_col;
  logic [2:0] src_col;
  logic [3:0] tgt_val;
  logic [3:0] src_val;
  logic [4:0] sum5;
  logic [4:0] red5;
  logic [1:0] row_zero;

  assign state_dbg = state;

  // The first edge after reset loads both history stages with the live keys,
  // so a key held across reset release never looks like a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= '0;
      key_prev <= '0;
      primed   <= 1'b0;
    end else begin
      key_q    <= {key_up, key_left, key_right, key_down, key_space};
      key_prev <= primed ? key_q : {key_up, key_left, key_right, key_down, key_space};
      primed   <= 1'b1;
    end
  end

  always_comb begin
    ev        = key_q & ~key_prev;
    act_up    = ev[4];
    act_left  = ev[3] & ~ev[4];
    act_right = ev[2] & ~|ev[4:3];
    act_down  = ev[1] & ~|ev[4:2];
    act_space = ev[0] & ~|ev[4:1];
  end

  always_comb begin
    if (num_slots < 3'd2)      n_new = 3'd2;
    else if (num_slots > MAX_N) n_new = MAX_N;
    else                        n_new = num_slots;
  end

  always_comb begin
    n_m1    = n_act - 3'd1;
    nxt_row = cur_row;
    nxt_col = cur_col;
    if (act_up || act_down)  nxt_row = ~cur_row;
    else if (act_left)       nxt_col = (cur_col == 3'd0) ? n_m1 : cur_col - 3'd1;
    else if (act_right)      nxt_col = (cur_col == n_m1) ? 3'd0 : cur_col + 3'd1;
  end

  // Target always lives in the current player's row; the source is the other pick.
  always_comb begin
    tgt_col = (sel_row == cur_player) ? sel_col : cur_col;
    src_col = (sel_row == cur_player) ? cur_col : sel_col;
    tgt_val = 4'd0;
    src_val = 4'd0;
    for (int c = 0; c < MAX_SLOTS; c++) begin
      if (3'(c) == tgt_col) tgt_val = vals[cur_player][c];
      if (3'(c) == src_col) src_val = vals[~cur_player][c];
    end
    sum5 = {1'b0, tgt_val} + {1'b0, src_val};
    red5 = (sum5 >= MOD5) ? sum5 - MOD5 : sum5;
  end

  always_comb begin
    row_zero = 2'b11;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < MAX_SLOTS; c++)
        if (vals[r][c] != 4'd0) row_zero[r] = 1'b0;
  end

  always_comb begin
    slot_vals = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < MAX_SLOTS; c++)
        slot_vals[(r*MAX_SLOTS+c)*4 +: 4] = vals[r][c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      n_act      <= 3'd2;
      zero_cnt   <= 3'd0;
      cur_row    <= 1'b0;
      cur_col    <= 3'd0;
      sel_row    <= 1'b0;
      sel_col    <= 3'd0;
      selecting  <= 1'b0;
      cur_player <= 1'b0;
      game_end   <= 2'd0;
      move_done  <= 1'b0;
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < MAX_SLOTS; c++)
          vals[r][c] <= 4'd0;
    end else begin
      move_done <= 1'b0;
      if (start) begin
        state      <= PICK_SRC;
        n_act      <= n_new;
        zero_cnt   <= 3'd0;
        cur_row    <= 1'b0;
        cur_col    <= 3'd0;
        sel_row    <= 1'b0;
        sel_col    <= 3'd0;
        selecting  <= 1'b0;
        cur_player <= 1'b0;
        game_end   <= 2'd0;
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < MAX_SLOTS; c++)
            vals[r][c] <= (3'(c) < n_new) ? 4'd1 : 4'd0;
      end else begin
        case (state)
          PICK_SRC: begin
            if (act_space) begin
              sel_row   <= cur_row;
              sel_col   <= cur_col;
              selecting <= 1'b1;
              state     <= PICK_DST;
            end else begin
              cur_row <= nxt_row;
              cur_col <= nxt_col;
            end
          end
          PICK_DST: begin
            if (act_space) begin
              if (sel_row == cur_row) begin
                selecting <= 1'b0;
                move_done <= 1'b1;
                state     <= PICK_SRC;
              end else begin
                state <= APPLY;
              end
            end else begin
              cur_row <= nxt_row;
              cur_col <= nxt_col;
            end
          end
          APPLY: begin
            if (tgt_val != 4'd0) begin
              for (int c = 0; c < MAX_SLOTS; c++)
                if (3'(c) == tgt_col) vals[cur_player][c] <= red5[3:0];
              if (src_val == 4'd0)
                zero_cnt <= (zero_cnt == ZL) ? zero_cnt : zero_cnt + 3'd1;
              else
                zero_cnt <= 3'd0;
            end
            cur_player <= ~cur_player;
            selecting  <= 1'b0;
            move_done  <= 1'b1;
            state      <= CHECK;
          end
          CHECK: begin
            if (row_zero[1]) begin
              game_end <= 2'd1;
              state    <= END;
            end else if (row_zero[0]) begin
              game_end <= 2'd2;
              state    <= END;
            end else if (zero_cnt == ZL) begin
              game_end <= 2'd3;
              state    <= END;
            end else begin
              state <= PICK_SRC;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
